// File: rtl/inexrecur_wr_packer.sv
// Write-side packer for the inexact-recursion parameter store: buffers {i,z,k,l}
// tuples in a 2-entry FIFO and streams packed words into the store's write port.
module inexrecur_wr_packer #(
  parameter int unsigned FIELD_W = 8,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FIELD_W-1:0]    in_i,
  input  logic [FIELD_W-1:0]    in_z,
  input  logic [FIELD_W-1:0]    in_k,
  input  logic [FIELD_W-1:0]    in_l,
  input  logic                  wr_hold,
  input  logic                  seal,
  output logic                  we,
  output logic [4*FIELD_W-1:0]  w_data,
  output logic [ADDR_W-1:0]     w_addr,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  sealed,
  output logic                  overflow_err
);

  localparam int unsigned WORD_W = 4 * FIELD_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FULL   = 2'd1,
    ST_SEALED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               seal_pend_q, seal_pend_d;
  logic [WORD_W-1:0]  fifo_mem_q [2];
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         fifo_cnt_q;
  logic [1:0]         fifo_cnt_after_c;
  logic               pop_c, push_c, drop_c;
  logic               flush_c, ovf_set_c;
  logic [CNT_W-1:0]   count_inc_c;

  // A word leaves the FIFO only while active, unheld and below capacity
  assign pop_c  = (state_q == ST_ACTIVE) && (fifo_cnt_q != 2'd0) && !wr_hold && (count < DEPTH_C);
  assign push_c = in_valid && in_ready && (state_q == ST_ACTIVE);
  assign drop_c = in_valid && in_ready && (state_q == ST_FULL);
  assign fifo_cnt_after_c = fifo_cnt_q + 2'(push_c) - 2'(pop_c);
  assign count_inc_c = count + CNT_W'(1);
  assign full = (count == DEPTH_C);

  always_comb begin : ready_logic
    in_ready = 1'b0;
    case (state_q)
      ST_ACTIVE: in_ready = ((fifo_cnt_q < 2'd2) || pop_c) && !seal_pend_q;
      ST_FULL:   in_ready = 1'b1;
      default:   in_ready = 1'b0;
    endcase
  end

  always_comb begin : next_state
    state_d     = state_q;
    seal_pend_d = seal_pend_q;
    flush_c     = 1'b0;
    ovf_set_c   = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        seal_pend_d = seal_pend_q | seal;
        if (pop_c && (count_inc_c == DEPTH_C)) begin
          // Store just filled: anything still buffered can never be written
          state_d   = ST_FULL;
          flush_c   = 1'b1;
          ovf_set_c = (fifo_cnt_after_c != 2'd0);
        end else if (seal_pend_d && (fifo_cnt_after_c == 2'd0) && !push_c) begin
          state_d = ST_SEALED;
        end
      end
      ST_FULL: begin
        ovf_set_c = drop_c;
        if (seal || seal_pend_q) state_d = ST_SEALED;
      end
      default: state_d = ST_SEALED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q     <= ST_ACTIVE;
      seal_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seal_pend_q <= seal_pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : fifo_reg
    if (!rst_n) begin
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else if (flush_c) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push_c) begin
        fifo_mem_q[wr_ptr_q] <= {in_i, in_z, in_k, in_l};
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_after_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : write_port
    if (!rst_n) begin
      we           <= 1'b0;
      w_data       <= '0;
      w_addr       <= '0;
      count        <= '0;
      sealed       <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      we <= pop_c;
      if (pop_c) begin
        w_data <= fifo_mem_q[rd_ptr_q];
        w_addr <= count[ADDR_W-1:0];
        count  <= count_inc_c;
      end
      sealed       <= (state_d == ST_SEALED);
      overflow_err <= overflow_err | ovf_set_c;
    end
  end

endmodule

// File: tb/tb_inexrecur_wr_packer.sv
// Bench for inexrecur_wr_packer: directed table, hand sequences and random traffic
// against a queue-based reference model; a DEPTH=4 instance covers capacity handling.
module tb_inexrecur_wr_packer;

  localparam int unsigned FW    = 8;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEP   = 4096;
  localparam int unsigned S_AW  = 2;
  localparam int unsigned S_DEP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, wr_hold, seal;
  logic [FW-1:0] in_i, in_z, in_k, in_l;

  logic          in_ready, we, full, sealed, overflow_err;
  logic [31:0]   w_data;
  logic [AW-1:0] w_addr;
  logic [AW:0]   count;

  logic            s_in_ready, s_we, s_full, s_sealed, s_ovf;
  logic [31:0]     s_w_data;
  logic [S_AW-1:0] s_w_addr;
  logic [S_AW:0]   s_count;

  inexrecur_wr_packer #(.FIELD_W(FW), .ADDR_W(AW), .DEPTH(DEP)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_z(in_z), .in_k(in_k), .in_l(in_l),
    .wr_hold(wr_hold), .seal(seal), .we(we), .w_data(w_data), .w_addr(w_addr),
    .count(count), .full(full), .sealed(sealed), .overflow_err(overflow_err)
  );

  inexrecur_wr_packer #(.FIELD_W(FW), .ADDR_W(S_AW), .DEPTH(S_DEP)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_i(in_i), .in_z(in_z), .in_k(in_k), .in_l(in_l),
    .wr_hold(wr_hold), .seal(seal), .we(s_we), .w_data(s_w_data), .w_addr(s_w_addr),
    .count(s_count), .full(s_full), .sealed(s_sealed), .overflow_err(s_ovf)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: store session as a tuple queue plus counters
  typedef enum int {M_ACT, M_FULL, M_SEALED} mst_t;
  logic [31:0] mq[$];
  int          m_count;
  mst_t        m_state;
  bit          m_pend, m_ovf, m_we;
  logic [31:0] m_wdata;
  int          m_waddr;
  bit          last_stall;
  logic        last_ready;

  function automatic void model_reset();
    mq.delete();
    m_count = 0; m_state = M_ACT; m_pend = 0; m_ovf = 0;
    m_we = 0; m_wdata = '0; m_waddr = 0;
  endfunction

  function automatic bit model_can_write();
    return (m_state == M_ACT) && (mq.size() > 0) && !wr_hold && (m_count < int'(DEP));
  endfunction

  function automatic bit model_ready();
    if (m_state == M_ACT) return ((mq.size() < 2) || model_can_write()) && !m_pend;
    return (m_state == M_FULL);
  endfunction

  function automatic void model_step();
    bit          can_w = model_can_write();
    bit          xfer  = in_valid && model_ready();
    logic [31:0] word  = {in_i, in_z, in_k, in_l};
    last_stall = in_valid && !model_ready();
    m_we = 0;
    case (m_state)
      M_ACT: begin
        if (can_w) begin
          m_we = 1; m_wdata = mq.pop_front(); m_waddr = m_count; m_count++;
        end
        if (xfer) mq.push_back(word);
        if (seal) m_pend = 1;
        if (m_count == int'(DEP)) begin
          m_state = M_FULL;
          if (mq.size() > 0) m_ovf = 1;
          mq.delete();
        end else if (m_pend && mq.size() == 0 && !xfer) begin
          m_state = M_SEALED;
        end
      end
      M_FULL: begin
        if (xfer) m_ovf = 1;
        if (seal || m_pend) m_state = M_SEALED;
      end
      default: ;
    endcase
  endfunction

  // One clock: check in_ready mid-cycle, advance model, check outputs after the edge
  task automatic cycle();
    @(negedge clk);
    last_ready = in_ready;
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
    model_step();
    @(posedge clk);
    #1;
    chk("we", 64'(we), 64'(m_we));
    chk("w_data", 64'(w_data), 64'(m_wdata));
    chk("w_addr", 64'(w_addr), 64'(m_waddr));
    chk("count", 64'(count), 64'(m_count));
    chk("full", 64'(full), 64'(m_count == int'(DEP)));
    chk("sealed", 64'(sealed), 64'(m_state == M_SEALED));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
  endtask

  task automatic set_in(input bit v, input logic [31:0] t, input bit h, input bit s);
    in_valid = v; {in_i, in_z, in_k, in_l} = t; wr_hold = h; seal = s;
  endtask

  task automatic do_reset();
    set_in(0, 32'h0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    last_stall = 0;
    #1;
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_w_data", 64'(w_data), 64'(0));
    chk("rst_w_addr", 64'(w_addr), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_sealed", 64'(sealed), 64'(0));
    chk("rst_overflow", 64'(overflow_err), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] tup;
    bit          hold;
    bit          rdy;
    bit          we;
    logic [31:0] wd;
    logic [11:0] wa;
    logic [12:0] cnt;
  } vec_t;
  vec_t tbl[11];

  task automatic rand_run(input int n, input int seal_at, input int seal_odds);
    for (int c = 0; c < n; c++) begin
      if (!last_stall) begin
        in_valid = ($urandom_range(0, 9) < 7);
        {in_i, in_z, in_k, in_l} = $urandom;
      end
      wr_hold = ($urandom_range(0, 3) == 0);
      seal = (c == seal_at) || (seal_odds > 0 && $urandom_range(0, seal_odds - 1) == 0);
      cycle();
    end
  endtask

  initial begin
    int nw;
    rst_n = 1'b0;
    set_in(0, 32'h0, 0, 0);

    // single push, then hold-induced backpressure and drain in order
    tbl[0]  = '{1, 32'h01020304, 0, 1, 0, 32'h0,        12'd0, 13'd0};
    tbl[1]  = '{0, 32'h0,        0, 1, 1, 32'h01020304, 12'd0, 13'd1};
    tbl[2]  = '{1, 32'h11121314, 1, 1, 0, 32'h01020304, 12'd0, 13'd1};
    tbl[3]  = '{1, 32'h21222324, 1, 1, 0, 32'h01020304, 12'd0, 13'd1};
    tbl[4]  = '{1, 32'h31323334, 1, 0, 0, 32'h01020304, 12'd0, 13'd1};
    tbl[5]  = '{1, 32'h31323334, 1, 0, 0, 32'h01020304, 12'd0, 13'd1};
    tbl[6]  = '{1, 32'h31323334, 1, 0, 0, 32'h01020304, 12'd0, 13'd1};
    tbl[7]  = '{1, 32'h31323334, 0, 1, 1, 32'h11121314, 12'd1, 13'd2};
    tbl[8]  = '{0, 32'h0,        0, 1, 1, 32'h21222324, 12'd2, 13'd3};
    tbl[9]  = '{0, 32'h0,        0, 1, 1, 32'h31323334, 12'd3, 13'd4};
    tbl[10] = '{0, 32'h0,        0, 1, 0, 32'h31323334, 12'd3, 13'd4};

    #1;
    do_reset();
    for (int r = 0; r < 11; r++) begin
      set_in(tbl[r].v, tbl[r].tup, tbl[r].hold, 0);
      cycle();
      chk($sformatf("tbl%0d_ready", r), 64'(last_ready), 64'(tbl[r].rdy));
      chk($sformatf("tbl%0d_we", r), 64'(we), 64'(tbl[r].we));
      chk($sformatf("tbl%0d_wdata", r), 64'(w_data), 64'(tbl[r].wd));
      chk($sformatf("tbl%0d_waddr", r), 64'(w_addr), 64'(tbl[r].wa));
      chk($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].cnt));
    end

    // back-to-back burst of 8
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_in(c < 8, {8'(c + 1), 8'hA0, 8'hB0, 8'hC0}, 0, 0);
      cycle();
      if (c < 8) chk("b2b_ready", 64'(last_ready), 64'(1));
      if (c >= 1 && c <= 8) begin
        chk("b2b_we", 64'(we), 64'(1));
        chk("b2b_waddr", 64'(w_addr), 64'(c - 1));
        chk("b2b_wdata", 64'(w_data), 64'({8'(c), 8'hA0, 8'hB0, 8'hC0}));
      end
    end

    // capacity on the DEPTH=4 instance
    do_reset();
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      set_in(c < 6, {8'(c + 1), 8'h44, 8'h55, 8'h66}, 0, 0);
      cycle();
      if (s_we) begin
        chk("cap_wdata", 64'(s_w_data), 64'({8'(nw + 1), 8'h44, 8'h55, 8'h66}));
        chk("cap_waddr", 64'(s_w_addr), 64'(nw));
        nw++;
      end
    end
    chk("cap_writes", 64'(nw), 64'(4));
    chk("cap_count", 64'(s_count), 64'(4));
    chk("cap_full", 64'(s_full), 64'(1));
    chk("cap_overflow", 64'(s_ovf), 64'(1));
    @(negedge clk);
    chk("cap_ready", 64'(s_in_ready), 64'(1));
    @(posedge clk);
    #1;

    // seal with two buffered tuples under hold
    do_reset();
    set_in(1, 32'hAABBCC01, 1, 0); cycle();
    set_in(1, 32'hAABBCC02, 1, 0); cycle();
    set_in(0, 32'h0, 1, 1);        cycle();
    set_in(0, 32'h0, 1, 0);        cycle();
    chk("seal_ready", 64'(last_ready), 64'(0));
    nw = 0;
    for (int c = 0; c < 5; c++) begin
      set_in(c == 4, 32'h12345678, 0, 0);
      cycle();
      if (we) nw++;
    end
    chk("seal_writes", 64'(nw), 64'(2));
    chk("seal_sealed", 64'(sealed), 64'(1));
    chk("seal_count", 64'(count), 64'(2));
    chk("seal_wdata", 64'(w_data), 64'(32'hAABBCC02));

    // reset in the middle of a burst
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(1, {8'(c + 1), 8'h77, 8'h88, 8'h99}, c == 4, 0);
      cycle();
    end
    chk("midrst_count_before", 64'(count), 64'(3));
    #2;
    do_reset();
    set_in(1, 32'hDEADBEEF, 0, 0); cycle();
    set_in(0, 32'h0, 0, 0);        cycle();
    chk("midrst_we", 64'(we), 64'(1));
    chk("midrst_waddr", 64'(w_addr), 64'(0));
    chk("midrst_wdata", 64'(w_data), 64'(32'hDEADBEEF));

    // long random run through capacity, then a seal in FULL
    do_reset();
    rand_run(11500, 11000, 0);
    chk("rand_full", 64'(full), 64'(1));
    chk("rand_sealed", 64'(sealed), 64'(1));

    // short random run with occasional seals while active
    do_reset();
    rand_run(400, -1, 150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
